// File: rtl/memarb_pkg.sv
// rtl/memarb_pkg.sv - shared state and owner encodings for mem_arbiter
// MEMARB_ALIGN_CHECK_EN adds the ERR state.
package memarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
`ifdef MEMARB_ALIGN_CHECK_EN
        ,
        ST_ERR   = 2'd3
`endif
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/memarb_pick.sv
// rtl/memarb_pick.sv - combinational grant selection between fetch and memory stage
// A requester in its done cycle is skipped; dm wins unless fetch is owed a turn.
import memarb_pkg::*;

module memarb_pick (
    input  logic if_req,
    input  logic dm_req,
    input  logic if_done,
    input  logic dm_done,
    input  logic if_owed,
    output logic grant_valid,
    output logic grant_owner
);

    logic if_ok;
    logic dm_ok;

    always_comb begin
        if_ok       = if_req & ~if_done;
        dm_ok       = dm_req & ~dm_done;
        grant_valid = if_ok | dm_ok;
        if (if_ok && (if_owed || !dm_ok)) begin
            grant_owner = OWN_IF;
        end else begin
            grant_owner = OWN_DM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for fetch and memory stage
// Optional MEMARB_ALIGN_CHECK_EN rejects odd addresses through an ERR state.
import memarb_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_stall,
    input  logic              mem_done,
    output logic              err
);

    state_t            state;
    state_t            state_n;
    logic              own_q;
    logic              if_owed;
    logic              grant_valid;
    logic              grant_owner;
    logic              grant_wr;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;
    logic              load;
    logic              finish;
    logic              fail;

    memarb_pick u_pick (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .if_done    (if_done),
        .dm_done    (dm_done),
        .if_owed    (if_owed),
        .grant_valid(grant_valid),
        .grant_owner(grant_owner)
    );

    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

    // Fetch grants are always reads with no write data.
    always_comb begin
        grant_addr  = (grant_owner == OWN_DM) ? dm_addr : if_addr;
        grant_wr    = (grant_owner == OWN_DM) & dm_wr;
        grant_wdata = (grant_owner == OWN_DM) ? dm_wdata : '0;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        finish  = 1'b0;
        fail    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    load    = 1'b1;
                    state_n = ST_ISSUE;
`ifdef MEMARB_ALIGN_CHECK_EN
                    if (grant_addr[0]) begin
                        state_n = ST_ERR;
                    end
`endif
                end
            end
            ST_ISSUE: begin
                if (!mem_stall) begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_done) begin
                    finish  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
`ifdef MEMARB_ALIGN_CHECK_EN
            ST_ERR: begin
                fail    = 1'b1;
                state_n = ST_IDLE;
            end
`endif
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // mem_en is simply "ISSUE next cycle", so it is registered with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q     <= OWN_IF;
            if_owed   <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            err       <= 1'b0;
        end else begin
            mem_en  <= (state_n == ST_ISSUE);
            if_done <= 1'b0;
            dm_done <= 1'b0;
            err     <= fail;

            if (load) begin
                own_q     <= grant_owner;
                mem_wr    <= grant_wr;
                mem_addr  <= grant_addr;
                mem_wdata <= grant_wdata;
            end

            if (load && grant_owner == OWN_IF) begin
                if_owed <= 1'b0;
            end else if (if_req && ((load && grant_owner == OWN_DM) ||
                                    (state != ST_IDLE && own_q == OWN_DM))) begin
                if_owed <= 1'b1;
            end

            if (finish || fail) begin
                if (own_q == OWN_DM) begin
                    dm_done <= 1'b1;
                end else begin
                    if_done <= 1'b1;
                end
            end

            if (finish && !mem_wr) begin
                if (own_q == OWN_DM) begin
                    dm_rdata <= mem_rdata;
                end else begin
                    if_rdata <= mem_rdata;
                end
            end

            if (fail) begin
                if (own_q == OWN_DM) begin
                    dm_rdata <= '0;
                end else begin
                    if_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
// Honors MEMARB_ALIGN_CHECK_EN when defined.
module tb_mem_arbiter;

`ifdef MEMARB_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req = 1'b0;
    logic        dm_wr = 1'b0;
    logic [15:0] dm_addr = '0;
    logic [15:0] dm_wdata = '0;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_stall = 1'b0;
    logic        mem_done = 1'b0;
    logic        err;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_done(mem_done),
        .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit rnd = 1'b0;
    bit stop_new = 1'b0;
    int fix_lat = 1;
    int fix_stall = 0;

    logic [15:0] mem_arr [256];
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_data = '0;
    bit          issue_seen = 1'b0;
    int          stall_left = 0;

    // Transaction-level reference: who holds the memory, and what must be visible.
    int          m_own;
    bit          m_acc, m_bad, m_wr, m_owed;
    logic [15:0] m_addr, m_wdata;
    logic        e_mem_en, e_mem_wr, e_if_done, e_dm_done, e_err;
    logic [15:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_dm_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_acc = 0; m_bad = 0; m_wr = 0; m_owed = 0;
        m_addr = '0; m_wdata = '0;
        e_mem_en = 0; e_mem_wr = 0; e_if_done = 0; e_dm_done = 0; e_err = 0;
        e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_dm_rdata = '0;
    endtask

    task automatic finish_txn(input logic [15:0] rd, input bit upd, input bit is_err);
        if (m_own == 1) begin
            e_if_done = 1'b1;
            if (upd) e_if_rdata = rd;
        end else begin
            e_dm_done = 1'b1;
            if (upd) e_dm_rdata = rd;
        end
        e_err = is_err;
        m_own = 0;
    endtask

    task automatic model_step();
        bit if_ok;
        bit dm_ok;
        int w;
        if_ok = (if_req === 1'b1) && !e_if_done;
        dm_ok = (dm_req === 1'b1) && !e_dm_done;
        e_if_done = 1'b0; e_dm_done = 1'b0; e_err = 1'b0;
        if (m_own == 0) begin
            w = 0;
            if (if_ok && (m_owed || !dm_ok)) w = 1;
            else if (dm_ok) w = 2;
            if (w != 0) begin
                m_own   = w;
                m_wr    = (w == 2) && dm_wr;
                m_addr  = (w == 2) ? dm_addr : if_addr;
                m_wdata = dm_wdata;
                m_owed  = (w == 2) ? (m_owed || if_req) : 1'b0;
                m_bad   = ALIGN && m_addr[0];
                m_acc   = 1'b0;
                e_mem_en    = !m_bad;
                e_mem_wr    = m_wr;
                e_mem_addr  = m_addr;
                e_mem_wdata = m_wdata;
            end
        end else begin
            if (m_own == 2 && if_req) m_owed = 1'b1;
            if (m_bad) begin
                finish_txn(16'h0000, 1'b1, 1'b1);
            end else if (!m_acc) begin
                if (!mem_stall) begin
                    m_acc = 1'b1;
                    e_mem_en = 1'b0;
                end
            end else if (mem_done) begin
                finish_txn(mem_rdata, !m_wr, 1'b0);
            end
        end
    endtask

    task automatic mem_accept();
        if (mem_en && !mem_stall) begin
            if (mem_wr) mem_arr[mem_addr[7:0]] = mem_wdata;
            pend      = 1'b1;
            pend_data = mem_arr[mem_addr[7:0]];
            pend_cnt  = rnd ? int'($urandom_range(0, 3)) : fix_lat;
        end
    endtask

    task automatic mem_drive();
        mem_done  = 1'b0;
        mem_rdata = 16'($urandom);
        if (pend) begin
            if (pend_cnt == 0) begin
                mem_done  = 1'b1;
                mem_rdata = pend_data;
                pend      = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (mem_en) begin
            if (!issue_seen) begin
                issue_seen = 1'b1;
                stall_left = rnd ? int'($urandom_range(0, 2)) : fix_stall;
            end
            mem_stall = (stall_left > 0);
            if (stall_left > 0) stall_left--;
        end else begin
            issue_seen = 1'b0;
            mem_stall  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = 16'($urandom_range(0, 255));
        if (ALIGN && $urandom_range(0, 7) != 0) a[0] = 1'b0;
        return a;
    endfunction

    task automatic req_drive(input bit pif, input bit pdm);
        if (!if_req || pif) begin
            if_req  = !stop_new && ($urandom_range(0, 3) != 0);
            if_addr = rand_addr();
        end
        if (!dm_req || pdm) begin
            dm_req   = !stop_new && ($urandom_range(0, 2) != 0);
            dm_wr    = 1'($urandom_range(0, 1));
            dm_addr  = rand_addr();
            dm_wdata = 16'($urandom);
        end
    endtask

    task automatic check_outputs();
        chk("mem_en", 32'(mem_en), 32'(e_mem_en));
        if (e_mem_en) begin
            chk("mem_wr", 32'(mem_wr), 32'(e_mem_wr));
            chk("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
            if (e_mem_wr) chk("mem_wdata", 32'(mem_wdata), 32'(e_mem_wdata));
        end
        chk("if_done", 32'(if_done), 32'(e_if_done));
        chk("dm_done", 32'(dm_done), 32'(e_dm_done));
        chk("if_rdata", 32'(if_rdata), 32'(e_if_rdata));
        chk("dm_rdata", 32'(dm_rdata), 32'(e_dm_rdata));
        chk("err", 32'(err), 32'(e_err));
        chk("if_stall", 32'(if_stall), 32'(if_req & ~e_if_done));
        chk("dm_stall", 32'(dm_stall), 32'(dm_req & ~e_dm_done));
    endtask

    // One clock: model and memory sample pre-edge values, inputs move 1 after the edge.
    task automatic cycle();
        bit pif;
        bit pdm;
        @(posedge clk);
        pif = e_if_done;
        pdm = e_dm_done;
        mem_accept();
        if (rst_n) model_step();
        else model_reset();
        #1;
        mem_drive();
        if (rnd) req_drive(pif, pdm);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got[$];
        logic [15:0] exp_g [4];
        int ndone;
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'($urandom);
        model_reset();
        repeat (3) cycle();
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_if_rdata", 32'(if_rdata), 32'h0);
        chk("rst_dm_done", 32'(dm_done), 32'h0);
        rst_n = 1'b1;
        cycle();

        // single fetch read
        mem_arr[8'h10] = 16'hBEEF;
        if_addr = 16'h0010; if_req = 1'b1;
        cycle();
        chk("t1_c1_mem_en", 32'(mem_en), 32'h1);
        chk("t1_c1_mem_addr", 32'(mem_addr), 32'h0010);
        chk("t1_c1_mem_wr", 32'(mem_wr), 32'h0);
        cycle();
        chk("t1_c2_mem_en", 32'(mem_en), 32'h0);
        cycle();
        chk("t1_c3_if_done", 32'(if_done), 32'h0);
        cycle();
        chk("t1_c4_if_done", 32'(if_done), 32'h1);
        chk("t1_c4_if_rdata", 32'(if_rdata), 32'hBEEF);
        if_req = 1'b0;
        repeat (2) cycle();

        // simultaneous dm write and fetch read
        mem_arr[8'h02] = 16'h0F0F;
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
        if_req = 1'b1; if_addr = 16'h0002;
        cycle();
        chk("t2_c1_mem_wr", 32'(mem_wr), 32'h1);
        chk("t2_c1_mem_addr", 32'(mem_addr), 32'h0020);
        chk("t2_c1_mem_wdata", 32'(mem_wdata), 32'h1234);
        repeat (3) cycle();
        chk("t2_c4_dm_done", 32'(dm_done), 32'h1);
        chk("t2_c4_if_stall", 32'(if_stall), 32'h1);
        dm_req = 1'b0; dm_wr = 1'b0;
        cycle();
        chk("t2_c5_mem_en", 32'(mem_en), 32'h1);
        chk("t2_c5_mem_addr", 32'(mem_addr), 32'h0002);
        repeat (2) cycle();
        chk("t2_c7_if_stall", 32'(if_stall), 32'h1);
        cycle();
        chk("t2_c8_if_done", 32'(if_done), 32'h1);
        chk("t2_c8_if_rdata", 32'(if_rdata), 32'h0F0F);
        chk("t2_c8_if_stall", 32'(if_stall), 32'h0);
        chk("t2_mem_written", 32'(mem_arr[8'h20]), 32'h1234);
        if_req = 1'b0;
        repeat (2) cycle();

        // memory stall for three cycles in ISSUE
        mem_arr[8'h30] = 16'h5A5A; fix_stall = 3;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0030;
        for (int c = 1; c <= 4; c++) begin
            cycle();
            chk("t3_mem_en_held", 32'(mem_en), 32'h1);
            chk("t3_mem_addr_held", 32'(mem_addr), 32'h0030);
        end
        cycle();
        chk("t3_c5_mem_en", 32'(mem_en), 32'h0);
        cycle();
        chk("t3_c6_dm_done", 32'(dm_done), 32'h0);
        cycle();
        chk("t3_c7_dm_done", 32'(dm_done), 32'h1);
        chk("t3_c7_dm_rdata", 32'(dm_rdata), 32'h5A5A);
        dm_req = 1'b0; fix_stall = 0;
        repeat (2) cycle();

`ifdef MEMARB_ALIGN_CHECK_EN
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0021;
        cycle();
        chk("t6_c1_mem_en", 32'(mem_en), 32'h0);
        cycle();
        chk("t6_c2_dm_done", 32'(dm_done), 32'h1);
        chk("t6_c2_err", 32'(err), 32'h1);
        chk("t6_c2_dm_rdata", 32'(dm_rdata), 32'h0);
        dm_req = 1'b0;
        repeat (2) cycle();
`endif

        // reset while waiting; the late mem_done must be ignored
        fix_lat = 3;
        if_req = 1'b1; if_addr = 16'h0010;
        repeat (2) cycle();
        rst_n = 1'b0; if_req = 1'b0;
        #1;
        chk("t5_rst_if_rdata", 32'(if_rdata), 32'h0);
        chk("t5_rst_mem_en", 32'(mem_en), 32'h0);
        cycle();
        rst_n = 1'b1;
        for (int c = 4; c <= 8; c++) begin
            cycle();
            chk("t5_no_done", 32'(if_done), 32'h0);
        end
        fix_lat = 1;

        // continuous contention: grants must alternate dm, if, dm, if
        exp_g[0] = 16'h0080; exp_g[1] = 16'h0040; exp_g[2] = 16'h0081; exp_g[3] = 16'h0041;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0080;
        if_req = 1'b1; if_addr = 16'h0040;
        ndone = 0;
        for (int c = 0; c < 80 && ndone < 4; c++) begin
            bit was_en;
            was_en = mem_en;
            cycle();
            if (mem_en && !was_en) got.push_back(mem_addr);
            if (dm_done) begin
                ndone++;
                dm_addr = dm_addr + 16'h1;
                if (dm_addr == 16'h0082) dm_req = 1'b0;
            end
            if (if_done) begin
                ndone++;
                if_addr = if_addr + 16'h1;
                if (if_addr == 16'h0042) if_req = 1'b0;
            end
        end
        dm_req = 1'b0; if_req = 1'b0;
        chk("t4_done_count", 32'(ndone), 32'd4);
        chk("t4_grant_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("t4_grant_order", 32'(got[i]), 32'(exp_g[i]));
        repeat (2) cycle();

        // randomized traffic against the reference model
        rnd = 1'b1;
        repeat (3000) cycle();
        stop_new = 1'b1;
        for (int c = 0; c < 200 && (if_req || dm_req || m_own != 0); c++) cycle();
        chk("drain_idle", 32'(if_req || dm_req || m_own != 0), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
